// File: rtl/lbist_ctrl.sv
// Logic BIST sequencer: seeds the LFSR, alternates scan shift/capture windows,
// unloads the final response and checks the MISR signature against GOLDEN.
module lbist_ctrl #(
  parameter int                 CHAIN_LEN  = 32,
  parameter int                 N_PATTERNS = 1024,
  parameter int                 SIG_W      = 21,
  parameter logic [SIG_W-1:0]   GOLDEN     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             lfsr_seed_ld,
  output logic             lfsr_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             scan_en,
  output logic             capture,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int SC_W = $clog2(CHAIN_LEN);
  localparam int PC_W = $clog2(N_PATTERNS + 1);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_TOTAL  = PC_W'(N_PATTERNS);

  typedef enum logic [2:0] {
    IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [PC_W-1:0] pat_cnt_q, pat_cnt_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  // Abort from any active state overrides the sequencing; in IDLE it only masks start.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      shift_cnt_d = '0;
      pat_cnt_d   = '0;
      pass_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) state_d = INIT;
        end
        INIT: begin
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          pass_d      = 1'b0;
          state_d     = SHIFT;
        end
        SHIFT, UNLOAD: begin
          if (shift_cnt_q == SHIFT_LAST) begin
            shift_cnt_d = '0;
            state_d     = (state_q == SHIFT) ? CAPTURE : COMPARE;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          pat_cnt_d = pat_cnt_q + 1'b1;
          state_d   = (pat_cnt_d == PAT_TOTAL) ? UNLOAD : SHIFT;
        end
        COMPARE: begin
          pass_d  = (misr_sig == GOLDEN);
          state_d = DONE;
        end
        DONE: begin
          if (!start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_seed_ld = 1'b0;
    lfsr_en      = 1'b0;
    misr_clr     = 1'b0;
    misr_en      = 1'b0;
    scan_en      = 1'b0;
    capture      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    case (state_q)
      INIT: begin
        lfsr_seed_ld = 1'b1;
        misr_clr     = 1'b1;
        busy         = 1'b1;
      end
      SHIFT, UNLOAD: begin
        scan_en = 1'b1;
        lfsr_en = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
      end
      CAPTURE: begin
        capture = 1'b1;
        busy    = 1'b1;
      end
      COMPARE: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = pass_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl: directed session scenarios followed by
// random start/abort/signature traffic, all against a cycle-position model.
module tb_lbist_ctrl;

  localparam int          L     = 4;
  localparam int          N     = 3;
  localparam logic [20:0] G     = 21'h0ABCD;
  localparam int          TOTAL = 1 + N * (L + 1) + L + 1;

  localparam logic [8:0] INIT_V  = 9'b101000100;
  localparam logic [8:0] SHIFT_V = 9'b010110100;
  localparam logic [8:0] CAP_V   = 9'b000001100;
  localparam logic [8:0] CMP_V   = 9'b000000100;

  logic        clk, rst_n, start, abort;
  logic [20:0] misr_sig;
  logic        lfsr_seed_ld, lfsr_en, misr_clr, misr_en, scan_en, capture, busy, done, pass;

  int checks   = 0;
  int failures = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode;
  int    m_k;
  logic  m_pass;

  int cycle = 0;
  int init_cyc = 0;
  int last_lat = -1;
  bit done_seen = 0;
  int cap_count = 0;

  lbist_ctrl #(.CHAIN_LEN(L), .N_PATTERNS(N), .SIG_W(21), .GOLDEN(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .misr_sig(misr_sig),
    .lfsr_seed_ld(lfsr_seed_ld), .lfsr_en(lfsr_en), .misr_clr(misr_clr),
    .misr_en(misr_en), .scan_en(scan_en), .capture(capture), .busy(busy),
    .done(done), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {lfsr_seed_ld, lfsr_en, misr_clr, misr_en, scan_en, capture, busy, done, pass};
  endfunction

  // Outputs follow from the position k inside a session, counted from INIT entry.
  function automatic logic [8:0] model_out();
    logic [8:0] v;
    v = '0;
    case (m_mode)
      M_DONE: v = {7'b0, 1'b1, m_pass};
      M_RUN: begin
        if (m_k == 0)                   v = INIT_V;
        else if (m_k <= N * (L + 1))    v = (((m_k - 1) % (L + 1)) == L) ? CAP_V : SHIFT_V;
        else if (m_k <= N * (L + 1) + L) v = SHIFT_V;
        else                            v = CMP_V;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic modelReset();
    m_mode = M_IDLE;
    m_k    = 0;
    m_pass = 1'b0;
  endtask

  task automatic modelClock(input logic s, input logic a, input logic [20:0] sig);
    if (!rst_n) begin
      modelReset();
    end else begin
      case (m_mode)
        M_IDLE: if (s && !a) begin m_mode = M_RUN; m_k = 0; end
        M_RUN: begin
          if (a)                      m_mode = M_IDLE;
          else if (m_k == TOTAL - 1) begin m_pass = (sig == G); m_mode = M_DONE; end
          else                        m_k++;
        end
        default: if (a || !s) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)", tag, observed, expected, cycle);
      end
  endtask

  task automatic checkInt(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [20:0] sig, input string tag);
    start    = s;
    abort    = a;
    misr_sig = sig;
    @(posedge clk);
    modelClock(s, a, sig);
    #1;
    cycle++;
    if (capture) cap_count++;
    if (lfsr_seed_ld) init_cyc = cycle;
    if (done && !done_seen) begin
      last_lat  = cycle - init_cyc;
      done_seen = 1'b1;
    end
    if (!done) done_seen = 1'b0;
    checkOutput(tag, dut_vec(), model_out());
  endtask

  initial begin
    logic       rs, ra;
    logic [20:0] rsig;

    // Reset / idle
    start = 1'b0; abort = 1'b0; misr_sig = '0; rst_n = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_outputs", dut_vec(), 9'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 21'($urandom), "idle");

    // Full session, matching signature
    cap_count = 0; last_lat = -1;
    for (int i = 0; i < TOTAL + 1; i++) applyStimulus(1'b1, 1'b0, G, "run_pass");
    checkInt("pass_latency", last_lat, TOTAL);
    checkInt("pass_captures", cap_count, N);
    checkOutput("pass_done", {7'b0, done, pass}, 9'b000000011);

    // Start held in DONE, release, retrigger into a failing session
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 21'($urandom), "done_hold");
    applyStimulus(1'b0, 1'b0, G, "done_release");
    cap_count = 0; last_lat = -1;
    applyStimulus(1'b1, 1'b0, 21'h0ABCC, "retrigger_init");
    checkOutput("retrigger_misr_clr", {8'b0, misr_clr}, 9'b1);
    for (int i = 0; i < TOTAL; i++) applyStimulus(1'b1, 1'b0, 21'h0ABCC, "run_fail");
    checkInt("fail_latency", last_lat, TOTAL);
    checkOutput("fail_done", {7'b0, done, pass}, 9'b000000010);
    applyStimulus(1'b0, 1'b0, '0, "fail_release");

    // Abort during shift of the second pattern, then a clean session
    applyStimulus(1'b1, 1'b0, G, "abort_init");
    for (int i = 0; i < L + 3; i++) applyStimulus(1'b1, 1'b0, G, "abort_pre");
    applyStimulus(1'b1, 1'b1, G, "abort_hit");
    applyStimulus(1'b0, 1'b0, G, "abort_idle");
    applyStimulus(1'b0, 1'b1, G, "abort_in_idle");
    applyStimulus(1'b1, 1'b1, G, "abort_blocks_start");
    cap_count = 0; last_lat = -1;
    for (int i = 0; i < TOTAL + 1; i++) applyStimulus(1'b1, 1'b0, G, "post_abort_run");
    checkInt("post_abort_latency", last_lat, TOTAL);
    checkInt("post_abort_captures", cap_count, N);
    applyStimulus(1'b0, 1'b0, G, "post_abort_release");

    // Asynchronous reset in the unload window
    for (int i = 0; i < 1 + N * (L + 1) + 2; i++) applyStimulus(1'b1, 1'b0, G, "pre_async");
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", dut_vec(), 9'b0);
    start = 1'b0;
    @(posedge clk); #2;
    checkOutput("async_reset_held", dut_vec(), 9'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, G, "after_async");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rs   = ($urandom_range(0, 7) != 0);
      ra   = ($urandom_range(0, 39) == 0);
      rsig = $urandom_range(0, 1) ? G : 21'($urandom);
      applyStimulus(rs, ra, rsig, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
